// File: rtl/blk_frame_scheduler.sv
// Purpose: meters decoded 8x8 YCbCr blocks into blocks_to_hdmi with frame cadence
//          (one block row, HGAP blanking, ..., last row, VGAP blanking) and marks sob/eob/sof.
// Latency: 1 cycle from an accepted upstream beat to blk_valid/blk_data_*.
// Backpressure: in_ready is high only in BLOCK; an upstream bubble in BLOCK leaves a hole
//          downstream and sets the sticky underrun flag (the cadence is not stretched).
// Ports: clk/rst_n (async active-low); en run enable (sampled in IDLE and at frame end);
//        in_valid/in_ready/in_data_{y,cr,cb} upstream beat; blk_valid/blk_data_*/blk_sob/
//        blk_eob/blk_sof downstream beat; busy, frame_done pulse, sticky underrun.
// Optional: define BLK_SCHED_STATS_EN to add frame_cnt (wrapping) and underrun_cyc (saturating).
module blk_frame_scheduler #(
  parameter int N             = 2,
  parameter int X_RES         = 2160,
  parameter int Y_RES         = 1200,
  parameter int H_BLANK_CYC   = 106,
  parameter int V_BLANK_LINES = 264
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0][7:0] in_data_y,
  input  logic signed [N-1:0][7:0] in_data_cr,
  input  logic signed [N-1:0][7:0] in_data_cb,
  output logic                    blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                    blk_sob,
  output logic                    blk_eob,
  output logic                    blk_sof,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
`ifdef BLK_SCHED_STATS_EN
  ,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             underrun_cyc
`endif
);

  localparam int BEATS       = 64 / N;
  localparam int BLK_PER_ROW = X_RES / 8;
  localparam int ROWS        = Y_RES / 8;
  localparam int HGAP_CYC    = H_BLANK_CYC * 8;
  localparam int VGAP_CYC    = V_BLANK_LINES * (X_RES / N + H_BLANK_CYC);

  localparam int BW = (BEATS > 1)       ? $clog2(BEATS)       : 1;
  localparam int KW = (BLK_PER_ROW > 1) ? $clog2(BLK_PER_ROW) : 1;
  localparam int RW = (ROWS > 1)        ? $clog2(ROWS)        : 1;
  localparam int HW = (HGAP_CYC > 1)    ? $clog2(HGAP_CYC)    : 1;
  localparam int VW = (VGAP_CYC > 1)    ? $clog2(VGAP_CYC)    : 1;
  // One gap counter serves both blanking states, so it is sized for the longer one.
  localparam int GW = (HW > VW) ? HW : VW;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [KW-1:0] BLK_LAST  = KW'(BLK_PER_ROW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [GW-1:0] HGAP_LAST = GW'(HGAP_CYC - 1);
  localparam logic [GW-1:0] VGAP_LAST = GW'(VGAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLOCK, HGAP, VGAP} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  beat_cnt;
  logic [KW-1:0]  blk_cnt;
  logic [RW-1:0]  row_cnt;
  logic [GW-1:0]  gap_cnt;

  logic xfer;
  logic beat_last;
  logic blk_last;
  logic hgap_done;
  logic vgap_done;

  assign xfer      = (state == BLOCK) && in_valid;
  assign beat_last = (beat_cnt == BEAT_LAST);
  assign blk_last  = (blk_cnt == BLK_LAST);
  assign hgap_done = (state == HGAP) && (gap_cnt == HGAP_LAST);
  assign vgap_done = (state == VGAP) && (gap_cnt == VGAP_LAST);

  assign in_ready   = (state == BLOCK);
  assign busy       = (state != IDLE);
  // Decoded from registered state/count, so it is high during the final VGAP cycle;
  // the next frame's first beat can be accepted on the very next cycle.
  assign frame_done = vgap_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = BLOCK;
      end
      BLOCK: begin
        if (xfer && beat_last && blk_last) state_nxt = HGAP;
      end
      HGAP: begin
        if (hgap_done) state_nxt = (row_cnt == ROW_LAST) ? VGAP : BLOCK;
      end
      VGAP: begin
        // en is only honoured here, so a frame that has started always completes.
        if (vgap_done) state_nxt = en ? BLOCK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position counters and sticky underrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      blk_cnt  <= '0;
      row_cnt  <= '0;
      gap_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          blk_cnt  <= '0;
          row_cnt  <= '0;
          gap_cnt  <= '0;
          if (en) underrun <= 1'b0;
        end
        BLOCK: begin
          if (!in_valid) underrun <= 1'b1;
          if (xfer) begin
            if (beat_last) begin
              beat_cnt <= '0;
              blk_cnt  <= blk_last ? '0 : blk_cnt + KW'(1);
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        HGAP: begin
          if (hgap_done) begin
            gap_cnt <= '0;
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        VGAP: begin
          gap_cnt <= vgap_done ? '0 : gap_cnt + GW'(1);
        end
        default: begin
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // Output pipeline: flags only on transfer cycles, data holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid   <= 1'b0;
      blk_sob     <= 1'b0;
      blk_eob     <= 1'b0;
      blk_sof     <= 1'b0;
      blk_data_y  <= '0;
      blk_data_cr <= '0;
      blk_data_cb <= '0;
    end else begin
      blk_valid <= xfer;
      blk_sob   <= xfer && (beat_cnt == '0);
      blk_eob   <= xfer && beat_last;
      blk_sof   <= xfer && (beat_cnt == '0) && (blk_cnt == '0) && (row_cnt == '0);
      if (xfer) begin
        blk_data_y  <= in_data_y;
        blk_data_cr <= in_data_cr;
        blk_data_cb <= in_data_cb;
      end
    end
  end

`ifdef BLK_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      underrun_cyc <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if ((state == BLOCK) && !in_valid && (underrun_cyc != 16'hFFFF))
        underrun_cyc <= underrun_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blk_frame_scheduler.sv
// Scoreboard bench for blk_frame_scheduler with small frame geometry
// (BEATS=32, 2 blocks/row, 2 rows, HGAP=32, VGAP=24).
module tb_blk_frame_scheduler;

  localparam int N     = 2;
  localparam int ROWB  = 64;   // beats per block row
  localparam int BEATS = 32;
  localparam int HGAPC = 32;
  localparam int VGAPC = 24;

  logic clk = 1'b0;
  logic rst_n, en, in_valid, in_ready;
  logic signed [N-1:0][7:0] in_data_y, in_data_cr, in_data_cb;
  logic blk_valid, blk_sob, blk_eob, blk_sof, busy, frame_done, underrun;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;
`ifdef BLK_SCHED_STATS_EN
  logic [15:0] frame_cnt, underrun_cyc;
`endif

  blk_frame_scheduler #(
    .N(N), .X_RES(16), .Y_RES(16), .H_BLANK_CYC(4), .V_BLANK_LINES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_y(in_data_y), .in_data_cr(in_data_cr), .in_data_cb(in_data_cb),
    .blk_valid(blk_valid),
    .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb),
    .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
`ifdef BLK_SCHED_STATS_EN
    , .frame_cnt(frame_cnt), .underrun_cyc(underrun_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        sob, eob, sof;
    logic [15:0] y, cr, cb;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Stimulus data is a pure function of the cycle number, so the expected
  // output of any transfer follows from the cycle it was issued in.
  function automatic logic [15:0] dy(input int c);
    logic [7:0] b = c[7:0];
    return {~b, b};
  endfunction
  function automatic logic [15:0] dcr(input int c);
    logic [7:0] b = c[7:0];
    return {b + 8'd1, b ^ 8'h5A};
  endfunction
  function automatic logic [15:0] dcb(input int c);
    logic [7:0] b = c[7:0];
    return {b + 8'd3, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    in_data_y  = dy(cyc);
    in_data_cr = dcr(cyc);
    in_data_cb = dcb(cyc);
  endtask

  // One block row; the bench expects acceptance on every cycle it offers a beat.
  task automatic run_row(input bit first_row, input int hole_at, input int hole_len,
                         input int drop_en_at);
    int b = 0;
    int h = hole_len;
    exp_t e;
    chk("in_ready_row_start", {31'd0, in_ready}, 32'd1);
    while (b < ROWB) begin
      if (b == drop_en_at) en = 1'b0;
      if (b == hole_at && h > 0) begin
        in_valid = 1'b0;
        h--;
      end else begin
        in_valid = 1'b1;
        e.cyc = cyc + 1;
        e.sob = (b % BEATS) == 0;
        e.eob = (b % BEATS) == BEATS - 1;
        e.sof = first_row && (b == 0);
        e.y   = dy(cyc);
        e.cr  = dcr(cyc);
        e.cb  = dcb(cyc);
        exp_q.push_back(e);
        b++;
      end
      step();
    end
  endtask

  // Blanking: in_valid stays high so any leaked transfer shows up downstream.
  task automatic gap(input int n, input bit is_vgap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      if (i == 0) begin
        chk("in_ready_gap", {31'd0, in_ready}, 32'd0);
        chk("busy_gap", {31'd0, busy}, 32'd1);
      end
      if (is_vgap) chk("frame_done_vgap", {31'd0, frame_done}, {31'd0, (i == n - 1)});
      step();
    end
  endtask

  task automatic run_frame(input int hole_at, input int hole_len, input int drop_en_at);
    run_row(1'b1, hole_at, hole_len, drop_en_at);
    gap(HGAPC, 1'b0);
    run_row(1'b0, -1, 0, -1);
    gap(HGAPC, 1'b0);
    gap(VGAPC, 1'b1);
  endtask

  // Monitor: every downstream beat must match the head of the queue, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("blk_sob", {31'd0, blk_sob}, {31'd0, e.sob});
          chk("blk_eob", {31'd0, blk_eob}, {31'd0, e.eob});
          chk("blk_sof", {31'd0, blk_sof}, {31'd0, e.sof});
          chk("blk_data_y", {16'h0, blk_data_y}, {16'h0, e.y});
          chk("blk_data_cr", {16'h0, blk_data_cr}, {16'h0, e.cr});
          chk("blk_data_cb", {16'h0, blk_data_cb}, {16'h0, e.cb});
        end
      end else begin
        chk("flags_idle", {29'd0, blk_sob, blk_eob, blk_sof}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0;
    in_data_y = '0; in_data_cr = '0; in_data_cb = '0;
    repeat (3) step();
    // Reset state
    chk("rst_blk_valid", {31'd0, blk_valid}, 32'd0);
    chk("rst_flags", {29'd0, blk_sob, blk_eob, blk_sof}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_data_y", {16'h0, blk_data_y}, 32'd0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Frame 1: clean, en held; frame 2 follows back to back.
    en = 1'b1;
    step();
    chk("busy_run", {31'd0, busy}, 32'd1);
    run_frame(-1, 0, -1);
    chk("underrun_clean", {31'd0, underrun}, 32'd0);

    // Frame 2: 3-cycle bubble at beat 10, en dropped during row 0.
    run_frame(10, 3, 20);
    chk("idle_after_frame_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_frame_in_ready", {31'd0, in_ready}, 32'd0);
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);
`ifdef BLK_SCHED_STATS_EN
    chk("frame_cnt", {16'h0, frame_cnt}, 32'd2);
    chk("underrun_cyc", {16'h0, underrun_cyc}, 32'd3);
`endif
    step();
    chk("idle_stays", {31'd0, busy}, 32'd0);

    // Frame 3: underrun cleared on leaving IDLE, then reset mid-HGAP.
    en = 1'b1;
    step();
    chk("underrun_cleared", {31'd0, underrun}, 32'd0);
    run_row(1'b1, 40, 1, -1);
    gap(10, 1'b0);
    chk("underrun_before_rst", {31'd0, underrun}, 32'd1);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_underrun", {31'd0, underrun}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_data_y", {16'h0, blk_data_y}, 32'd0);
    chk("arst_data_cb", {16'h0, blk_data_cb}, 32'd0);
    chk("arst_blk_valid", {31'd0, blk_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Frame 4 after reset: first beat carries sof; en dropped so it ends in IDLE.
    en = 1'b1;
    step();
    run_frame(-1, 0, 5);
    chk("final_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    step(); step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_frame_scheduler.md
Name: blk_frame_scheduler

Overview:
- Sits between the upstream decoded-block stream (8x8 YCbCr blocks, N pixels per beat) and blocks_to_hdmi.
- Meters blocks into blocks_to_hdmi with the frame cadence it expects:
  - one block row (X_RES/8 blocks);
  - then a horizontal-blanking gap of 8 lines' worth of blanking;
  - after the last block row, a vertical-blanking gap.
- Generates blk_sob, blk_eob and blk_sof itself, and flags upstream underrun.

Parameters:
- N, 2, pixels per beat per component; 64 must be divisible by N.
- X_RES, 2160, active pixels per line; multiple of 8.
- Y_RES, 1200, active lines per frame; multiple of 8.
- H_BLANK_CYC, 106, horizontal blanking cycles per line (front porch + back porch + sync).
- V_BLANK_LINES, 264, vertical blanking lines per frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; sampled only in IDLE and at frame end.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accept; combinational, equals (state==BLOCK).
- in_data_y  in  signed [N-1:0][7:0]  upstream Y beat.
- in_data_cr  in  signed [N-1:0][7:0]  upstream Cr beat.
- in_data_cb  in  signed [N-1:0][7:0]  upstream Cb beat.
- blk_valid  out  1  beat valid to blocks_to_hdmi.
- blk_data_y  out  signed [N-1:0][7:0]  registered Y.
- blk_data_cr  out  signed [N-1:0][7:0]  registered Cr.
- blk_data_cb  out  signed [N-1:0][7:0]  registered Cb.
- blk_sob  out  1  first beat of block.
- blk_eob  out  1  last beat of block.
- blk_sof  out  1  first beat of frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the VGAP count expires.
- underrun  out  1  sticky; set on any BLOCK-state cycle with in_valid=0; cleared only by reset or on entering BLOCK from IDLE.

Behaviour:
- Derived constants:
  - BEATS = 64/N
  - BLK_PER_ROW = X_RES/8
  - ROWS = Y_RES/8
  - HGAP = H_BLANK_CYC*8
  - VGAP = V_BLANK_LINES*(X_RES/N + H_BLANK_CYC)
  - Counter widths use $clog2 of each terminal value, minimum 1 bit.
- Reset (async, rst_n=0): state=IDLE; every output and every counter is 0; data outputs are 0.
- FSM states: IDLE, BLOCK, HGAP, VGAP.
  - IDLE → BLOCK when en=1; clears underrun and all counters.
  - BLOCK: a beat is transferred when in_valid=1.
    - beat_cnt increments per transfer.
    - When the transfer with beat_cnt=BEATS-1 occurs, beat_cnt←0 and blk_cnt increments.
    - When the last beat of block BLK_PER_ROW-1 transfers, blk_cnt←0 and state→HGAP.
    - in_valid=0 inserts an idle cycle: counters hold, blk_valid=0, underrun←1.
  - HGAP: counts HGAP cycles. On expiry:
    - if row_cnt=ROWS-1: row_cnt←0, state→VGAP;
    - otherwise: row_cnt increments, state→BLOCK.
  - VGAP: counts VGAP cycles. On expiry, frame_done pulses for 1 cycle, then:
    - state→BLOCK if en=1;
    - state→IDLE if en=0.
  - en dropping mid-frame has no effect until VGAP expiry; the frame always completes.
- Output pipeline: latency is exactly 1 cycle. On the transfer cycle T, registers load:
  - blk_valid←1 and data←in_data_*;
  - blk_sob←(beat_cnt==0);
  - blk_eob←(beat_cnt==BEATS-1);
  - blk_sof←(beat_cnt==0 && blk_cnt==0 && row_cnt==0).
  - On non-transfer cycles, blk_valid, blk_sob, blk_eob and blk_sof are 0. Data registers hold their last value.
- Gap counters count from 0 to terminal-1, giving exactly HGAP or VGAP cycles in state.
- The first BLOCK cycle after a gap may accept a beat. No dead cycles are inserted between back-to-back blocks within a row.

Optional Feature:
- Macro: BLK_SCHED_STATS_EN.
- Defined: adds two output ports.
  - frame_cnt out 16: increments on each frame_done; wraps at 65535→0.
  - underrun_cyc out 16: increments on each BLOCK cycle with in_valid=0; saturates at 65535.
  - Both reset to 0 only by rst_n.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- Small parameters for every scenario: N=2, X_RES=16, Y_RES=16, H_BLANK_CYC=4, V_BLANK_LINES=2. This gives BEATS=32, BLK_PER_ROW=2, ROWS=2, HGAP=32, VGAP=24.
- Reset then en=1, in_valid held 1 → 64 contiguous blk_valid beats per row.
  - blk_sob on beats 0 and 32; blk_eob on beats 31 and 63.
  - blk_sof only on the first beat of the frame.
  - Row starts exactly 32 idle cycles apart.
  - frame_done pulses 24 cycles after the final HGAP.
  - underrun=0.
- Incrementing data 1,2,3… on in_data_y → blk_data_y shows the same sequence exactly 1 cycle after each in_valid&&in_ready.
- Drop in_valid for 3 cycles at beat 10 of block 0 → blk_valid has a 3-cycle hole; blk_eob still falls on the 32nd transferred beat; underrun=1 and stays 1 through the frame.
  - With BLK_SCHED_STATS_EN: underrun_cyc=3.
- Drop en during row 0 → the frame completes, frame_done pulses once, state returns to IDLE (busy=0), in_ready=0.
- en held 1 for 2 frames → second blk_sof appears on the first BLOCK cycle after frame_done.
  - With BLK_SCHED_STATS_EN: frame_cnt=2.
- Assert rst_n=0 mid-HGAP → all outputs 0 immediately (asynchronously). After release with en=1, the next transferred beat carries blk_sof=1.
